// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART position-frame scheduler.
// Holds FSM state encoding, default frame header and the frame checksum helper.
// No logic of its own; imported by the scheduler top and its echo FIFO.
package uart_tx_scheduler_pkg;

    // Transmit scheduler states: IDLE arbitrates, HDR..CHK send a frame, ECHO sends one byte
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_P1   = 3'd2,
        ST_P2   = 3'd3,
        ST_CHK  = 3'd4,
        ST_ECHO = 3'd5
    } tx_state_e;

    localparam logic [7:0] FRAME_HDR_DEFAULT = 8'hA5;

    // Frame checksum covers the header and both position bytes
    function automatic logic [7:0] frame_checksum(input logic [7:0] hdr,
                                                  input logic [7:0] pos1,
                                                  input logic [7:0] pos2);
        return hdr ^ pos1 ^ pos2;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_echo_fifo.sv
// Echo FIFO: byte queue between the UART receiver and the transmit scheduler.
// Latency: a pushed byte is visible at head_o the cycle after the push.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
module uart_echo_fifo
    import uart_tx_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_i,
    input  logic [7:0] push_dat_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a full FIFO still takes a push alongside it
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy next-state; pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: sends 4-byte position frames on vsync edges and echoes received bytes.
// Latency: header offered the cycle after a vsync edge seen in IDLE; one echo byte per arbitration.
// Backpressure: tx_data/tx_valid hold until tx_ready; frames never interrupted, newer edge overwrites pending.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter logic [7:0] FRAME_HDR  = FRAME_HDR_DEFAULT,
    parameter int         ECHO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] r_vsync_i,
    input  logic [7:0] target_pos_in1,
    input  logic [7:0] target_pos_in2,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] frame_drop_cnt,
    output logic       echo_ovf
);

    tx_state_e  state_q;
    logic       tx_valid_q;
    logic [7:0] tx_data_q;
    logic       busy_q;
    logic [7:0] act_p1_q;
    logic [7:0] act_p2_q;

    logic       pend_vld_q, pend_vld_d;
    logic [7:0] pend_p1_q, pend_p1_d;
    logic [7:0] pend_p2_q, pend_p2_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       echo_ovf_q, echo_ovf_d;

    logic       frame_start;
    logic       in_idle;
    logic       take_frame;
    logic [7:0] src_p1;
    logic [7:0] src_p2;
    logic       tx_acc;

    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    assign frame_start = (r_vsync_i == 2'b10);
    assign in_idle     = (state_q == ST_IDLE);
    assign tx_acc      = tx_valid_q && tx_ready;

    // An edge seen directly in IDLE starts its frame at once, so the header appears one cycle later
    assign take_frame  = in_idle && (frame_start || pend_vld_q);
    assign src_p1      = frame_start ? target_pos_in1 : pend_p1_q;
    assign src_p2      = frame_start ? target_pos_in2 : pend_p2_q;

    assign fifo_pop    = (state_q == ST_ECHO) && tx_acc;
    assign fifo_push   = rx_valid;

    uart_echo_fifo #(
        .DEPTH (ECHO_DEPTH)
    ) u_echo_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (fifo_push),
        .push_dat_i (rx_data),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Pending frame bookkeeping: a newer edge replaces an unsent one and counts as a drop
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_p1_d  = pend_p1_q;
        pend_p2_d  = pend_p2_q;
        drop_cnt_d = drop_cnt_q;
        echo_ovf_d = echo_ovf_q;

        if (frame_start) begin
            pend_p1_d = target_pos_in1;
            pend_p2_d = target_pos_in2;
            if (pend_vld_q && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end

        if (take_frame) begin
            pend_vld_d = 1'b0;
        end else if (frame_start) begin
            pend_vld_d = 1'b1;
        end

        if (rx_valid && fifo_full && !fifo_pop) begin
            echo_ovf_d = 1'b1;
        end
    end

    // Pending, drop counter and overflow registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld_q <= 1'b0;
            pend_p1_q  <= 8'h00;
            pend_p2_q  <= 8'h00;
            drop_cnt_q <= 8'h00;
            echo_ovf_q <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_p1_q  <= pend_p1_d;
            pend_p2_q  <= pend_p2_d;
            drop_cnt_q <= drop_cnt_d;
            echo_ovf_q <= echo_ovf_d;
        end
    end

    // Transmit FSM with registered outputs; the next byte is loaded on acceptance of the current one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            act_p1_q   <= 8'h00;
            act_p2_q   <= 8'h00;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (take_frame) begin
                        state_q    <= ST_HDR;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= FRAME_HDR;
                        busy_q     <= 1'b1;
                        act_p1_q   <= src_p1;
                        act_p2_q   <= src_p2;
                    end else if (!fifo_empty) begin
                        state_q    <= ST_ECHO;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= fifo_head;
                        busy_q     <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (tx_acc) begin
                        state_q   <= ST_P1;
                        tx_data_q <= act_p1_q;
                    end
                end
                ST_P1: begin
                    if (tx_acc) begin
                        state_q   <= ST_P2;
                        tx_data_q <= act_p2_q;
                    end
                end
                ST_P2: begin
                    if (tx_acc) begin
                        state_q   <= ST_CHK;
                        tx_data_q <= frame_checksum(FRAME_HDR, act_p1_q, act_p2_q);
                    end
                end
                ST_CHK, ST_ECHO: begin
                    if (tx_acc) begin
                        state_q    <= ST_IDLE;
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_valid       = tx_valid_q;
    assign tx_data        = tx_data_q;
    assign busy           = busy_q;
    assign frame_drop_cnt = drop_cnt_q;
    assign echo_ovf       = echo_ovf_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: frame table plus hand-written stall, drop, echo and reset sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_scheduler;

    logic       clk;
    logic       reset_n;
    logic [1:0] r_vsync_i;
    logic [7:0] target_pos_in1;
    logic [7:0] target_pos_in2;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic [7:0] frame_drop_cnt;
    logic       echo_ovf;

    int total = 0;
    int bad   = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] p1;
        logic [7:0] p2;
        logic [7:0] cs;
    } frame_vec_t;

    frame_vec_t vecs[7];

    uart_tx_scheduler #(
        .FRAME_HDR  (8'hA5),
        .ECHO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .r_vsync_i      (r_vsync_i),
        .target_pos_in1 (target_pos_in1),
        .target_pos_in2 (target_pos_in2),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .frame_drop_cnt (frame_drop_cnt),
        .echo_ovf       (echo_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One-cycle vsync falling edge with the given positions; returns on the following falling edge
    task automatic pulse_edge(input logic [7:0] p1, input logic [7:0] p2);
        target_pos_in1 = p1;
        target_pos_in2 = p2;
        r_vsync_i      = 2'b10;
        tick();
        r_vsync_i      = 2'b00;
    endtask

    // Record every byte that will be accepted at the next rising edge, for a bounded number of cycles
    task automatic collect(input int ncyc);
        got.delete();
        for (int i = 0; i < ncyc; i++) begin
            if (tx_valid && tx_ready) got.push_back(tx_data);
            tick();
        end
    endtask

    task automatic chk_stream(input string nm);
        chk({nm, ".len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) chk(nm, int'(got[i]), int'(exp_q[i]));
        end
    endtask

    initial begin
        vecs[0] = '{p1: 8'h12, p2: 8'h34, cs: 8'h83};
        vecs[1] = '{p1: 8'h00, p2: 8'h00, cs: 8'hA5};
        vecs[2] = '{p1: 8'hFF, p2: 8'hFF, cs: 8'hA5};
        vecs[3] = '{p1: 8'h5A, p2: 8'h00, cs: 8'hFF};
        vecs[4] = '{p1: 8'hA5, p2: 8'hA5, cs: 8'hA5};
        vecs[5] = '{p1: 8'h01, p2: 8'h80, cs: 8'h24};
        vecs[6] = '{p1: 8'h3C, p2: 8'hC3, cs: 8'h5A};

        reset_n        = 1'b0;
        r_vsync_i      = 2'b00;
        target_pos_in1 = 8'h00;
        target_pos_in2 = 8'h00;
        rx_valid       = 1'b0;
        rx_data        = 8'h00;
        tx_ready       = 1'b1;
        tick();
        tick();
        chk("rst.tx_valid", int'(tx_valid), 0);
        chk("rst.tx_data", int'(tx_data), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.drop", int'(frame_drop_cnt), 0);
        chk("rst.ovf", int'(echo_ovf), 0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("idle.tx_valid", int'(tx_valid), 0);

        // Frame table, tx_ready tied high: four bytes on consecutive cycles then busy drops
        for (int v = 0; v < 7; v++) begin
            pulse_edge(vecs[v].p1, vecs[v].p2);
            chk("frm.hdr.vld", int'(tx_valid), 1);
            chk("frm.hdr", int'(tx_data), 8'hA5);
            chk("frm.busy", int'(busy), 1);
            tick();
            chk("frm.p1", int'(tx_data), int'(vecs[v].p1));
            tick();
            chk("frm.p2", int'(tx_data), int'(vecs[v].p2));
            tick();
            chk("frm.chk", int'(tx_data), int'(vecs[v].cs));
            chk("frm.chk.vld", int'(tx_valid), 1);
            tick();
            chk("frm.end.vld", int'(tx_valid), 0);
            chk("frm.end.busy", int'(busy), 0);
            tick();
        end
        chk("frm.drop", int'(frame_drop_cnt), 0);

        // Stall 20 cycles in P1: byte and valid hold, nothing skipped
        pulse_edge(8'h12, 8'h34);
        chk("stall.hdr", int'(tx_data), 8'hA5);
        tick();
        chk("stall.p1", int'(tx_data), 8'h12);
        tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall.hold.vld", int'(tx_valid), 1);
            chk("stall.hold.dat", int'(tx_data), 8'h12);
        end
        tx_ready = 1'b1;
        tick();
        chk("stall.p2", int'(tx_data), 8'h34);
        tick();
        chk("stall.chk", int'(tx_data), 8'h83);
        tick();
        chk("stall.end", int'(tx_valid), 0);

        // Three edges during one frame: middle one overwritten, last one sent afterwards
        pulse_edge(8'h11, 8'h22);
        tx_ready = 1'b0;
        tick();
        pulse_edge(8'h55, 8'h66);
        tick();
        pulse_edge(8'h77, 8'h88);
        chk("drop.cnt", int'(frame_drop_cnt), 1);
        tx_ready = 1'b1;
        collect(20);
        exp_q = '{8'hA5, 8'h11, 8'h22, 8'h96, 8'hA5, 8'h77, 8'h88, 8'h5A};
        chk_stream("drop.stream");
        chk("drop.busy", int'(busy), 0);

        // Five rx bytes during a stalled frame: four echoed after the checksum, overflow flagged
        pulse_edge(8'h12, 8'h34);
        tx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(k);
            tick();
        end
        rx_valid = 1'b0;
        chk("echo.ovf", int'(echo_ovf), 1);
        tx_ready = 1'b1;
        collect(30);
        exp_q = '{8'hA5, 8'h12, 8'h34, 8'h83, 8'h01, 8'h02, 8'h03, 8'h04};
        chk_stream("echo.stream");
        chk("echo.end.vld", int'(tx_valid), 0);

        // Echo byte and frame start together in IDLE: frame goes first
        rx_valid = 1'b1;
        rx_data  = 8'hAB;
        pulse_edge(8'h01, 8'h02);
        rx_valid = 1'b0;
        collect(20);
        exp_q = '{8'hA5, 8'h01, 8'h02, 8'hA6, 8'hAB};
        chk_stream("prio.stream");

        // Reset in P2: outputs clear at once, no resume, next edge starts with the header
        pulse_edge(8'h12, 8'h34);
        tick();
        tick();
        chk("rstmid.p2", int'(tx_data), 8'h34);
        reset_n = 1'b0;
        #1;
        chk("rstmid.vld", int'(tx_valid), 0);
        chk("rstmid.busy", int'(busy), 0);
        chk("rstmid.dat", int'(tx_data), 0);
        chk("rstmid.ovf", int'(echo_ovf), 0);
        chk("rstmid.drop", int'(frame_drop_cnt), 0);
        tick();
        reset_n = 1'b1;
        begin
            int highs;
            highs = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (tx_valid) highs++;
            end
            chk("rstmid.noresume", highs, 0);
        end
        pulse_edge(8'h5A, 8'h00);
        chk("rstmid.hdr", int'(tx_data), 8'hA5);
        collect(20);
        exp_q = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
        chk_stream("rstmid.stream");

        // Drop counter saturates at FF
        pulse_edge(8'h01, 8'h01);
        tx_ready = 1'b0;
        for (int i = 0; i < 260; i++) begin
            tick();
            r_vsync_i = 2'b10;
            tick();
            r_vsync_i = 2'b00;
        end
        tick();
        chk("sat.drop", int'(frame_drop_cnt), 8'hFF);
        tx_ready = 1'b1;
        collect(30);
        exp_q = '{8'hA5, 8'h01, 8'h01, 8'hA5, 8'hA5, 8'h01, 8'h01, 8'hA5};
        chk_stream("sat.stream");
        chk("sat.idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
